battle_turn_sequencer: RTL and testbench

//   Turn scheduler for the battle screen. Takes UART key bytes, the attack-bar

---
 rtl/battle_turn_sequencer_if.sv | 28 ++
 rtl/battle_turn_sequencer.sv | 164 ++++++++++++++++
 tb/tb_battle_turn_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/battle_turn_sequencer_if.sv
// Signal bundle between the battle turn sequencer and its environment.
// The master side drives key, tick and collision inputs; the slave side is the sequencer.
interface battle_turn_sequencer_if;
  logic       tick;
  logic [7:0] key;
  logic       key_valid;
  logic       atk_pass;
  logic [7:0] dmg_mon;
  logic       player_hit;
  logic [7:0] hit_dmg;
  logic [2:0] phase;
  logic [7:0] player_hp;
  logic [7:0] mon_hp;
  logic       bullet_en;
  logic       start_dmg;
  logic [7:0] turn_cnt;
  logic [1:0] game_over;

  modport master (
    output tick, key, key_valid, atk_pass, dmg_mon, player_hit, hit_dmg,
    input  phase, player_hp, mon_hp, bullet_en, start_dmg, turn_cnt, game_over
  );

  modport slave (
    input  tick, key, key_valid, atk_pass, dmg_mon, player_hit, hit_dmg,
    output phase, player_hp, mon_hp, bullet_en, start_dmg, turn_cnt, game_over
  );
endinterface

// File: rtl/battle_turn_sequencer.sv
// Battle-screen turn scheduler: select -> attack -> damage -> dodge, owning both HP pools.
// Every output comes straight from a register; the phase code is the FSM state itself.
module battle_turn_sequencer #(
  parameter logic [7:0] MAX_HP       = 8'd100,
  parameter logic [7:0] HEAL_AMT     = 8'd20,
  parameter int         ATK_TICKS    = 30,
  parameter int         BULLET_TICKS = 100,
  parameter logic [7:0] KEY_ATTACK   = 8'h20,
  parameter logic [7:0] KEY_HEAL     = 8'h68
) (
  input logic               clk,
  input logic               reset_n,
  battle_turn_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_ATTACK = 3'd2,
    S_APPLY  = 3'd3,
    S_DODGE  = 3'd4,
    S_CHECK  = 3'd5,
    S_WIN    = 3'd6,
    S_LOSE   = 3'd7
  } state_t;

  localparam logic [7:0] ATK_LAST    = 8'(ATK_TICKS - 1);
  localparam logic [7:0] BULLET_LAST = 8'(BULLET_TICKS - 1);

  state_t     r_state;
  logic [7:0] r_player_hp;
  logic [7:0] r_mon_hp;
  logic [7:0] r_dmg_latch;
  logic [7:0] r_turn_cnt;
  logic [7:0] r_tick_cnt;
  logic       r_bullet_en;
  logic       r_start_dmg;
  logic [1:0] r_game_over;

  logic       w_key_attack;
  logic       w_key_heal;
  logic [8:0] w_heal_sum;
  logic [7:0] w_heal_hp;
  logic [7:0] w_mon_after;
  logic [7:0] w_player_after;
  logic       w_atk_term;
  logic       w_dodge_term;

  assign w_key_attack   = bus.key_valid && (bus.key == KEY_ATTACK);
  assign w_key_heal     = bus.key_valid && (bus.key == KEY_HEAL);
  // Heal sum is formed in 9 bits so a near-full HP cannot wrap before the clamp.
  assign w_heal_sum     = {1'b0, r_player_hp} + {1'b0, HEAL_AMT};
  assign w_heal_hp      = (w_heal_sum > {1'b0, MAX_HP}) ? MAX_HP : w_heal_sum[7:0];
  assign w_mon_after    = (r_mon_hp > r_dmg_latch) ? (r_mon_hp - r_dmg_latch) : 8'd0;
  assign w_player_after = (r_player_hp > bus.hit_dmg) ? (r_player_hp - bus.hit_dmg) : 8'd0;
  assign w_atk_term     = bus.tick && (r_tick_cnt == ATK_LAST);
  assign w_dodge_term   = bus.tick && (r_tick_cnt == BULLET_LAST);

  // NOTE: every register here uses <= so all updates see pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_player_hp <= MAX_HP;
      r_mon_hp    <= MAX_HP;
      r_dmg_latch <= 8'd0;
      r_turn_cnt  <= 8'd0;
      r_tick_cnt  <= 8'd0;
      r_bullet_en <= 1'b0;
      r_start_dmg <= 1'b0;
      r_game_over <= 2'b00;
    end else begin
      r_start_dmg <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.key_valid) begin
            r_state     <= S_SELECT;
            r_player_hp <= MAX_HP;
            r_mon_hp    <= MAX_HP;
            r_turn_cnt  <= 8'd0;
            r_tick_cnt  <= 8'd0;
          end
        end
        S_SELECT: begin
          if (w_key_attack) begin
            r_state    <= S_ATTACK;
            r_tick_cnt <= 8'd0;
          end else if (w_key_heal) begin
            r_state     <= S_DODGE;
            r_player_hp <= w_heal_hp;
            r_bullet_en <= 1'b1;
            r_tick_cnt  <= 8'd0;
          end
        end
        S_ATTACK: begin
          // A strike key beats the timeout tick when both arrive together.
          if (w_key_attack) begin
            r_tick_cnt <= 8'd0;
            if (bus.atk_pass) begin
              r_state     <= S_APPLY;
              r_start_dmg <= 1'b1;
              r_dmg_latch <= bus.dmg_mon;
            end else begin
              r_state     <= S_DODGE;
              r_bullet_en <= 1'b1;
            end
          end else if (w_atk_term) begin
            r_state     <= S_DODGE;
            r_bullet_en <= 1'b1;
            r_tick_cnt  <= 8'd0;
          end else if (bus.tick) begin
            r_tick_cnt <= r_tick_cnt + 8'd1;
          end
        end
        S_APPLY: begin
          r_mon_hp   <= w_mon_after;
          r_tick_cnt <= 8'd0;
          if (w_mon_after == 8'd0) begin
            r_state     <= S_WIN;
            r_game_over <= 2'b01;
          end else begin
            r_state     <= S_DODGE;
            r_bullet_en <= 1'b1;
          end
        end
        S_DODGE: begin
          if (bus.player_hit) r_player_hp <= w_player_after;
          // A lethal hit outranks the end-of-dodge tick in the same cycle.
          if (bus.player_hit && (w_player_after == 8'd0)) begin
            r_state     <= S_LOSE;
            r_game_over <= 2'b10;
            r_bullet_en <= 1'b0;
            r_tick_cnt  <= 8'd0;
          end else if (w_dodge_term) begin
            r_state     <= S_CHECK;
            r_bullet_en <= 1'b0;
            r_tick_cnt  <= 8'd0;
          end else if (bus.tick) begin
            r_tick_cnt <= r_tick_cnt + 8'd1;
          end
        end
        S_CHECK: begin
          r_turn_cnt <= r_turn_cnt + 8'd1;
          r_state    <= S_SELECT;
        end
        S_WIN, S_LOSE: begin
          if (w_key_attack) begin
            r_state     <= S_IDLE;
            r_game_over <= 2'b00;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.phase     = r_state;
  assign bus.player_hp = r_player_hp;
  assign bus.mon_hp    = r_mon_hp;
  assign bus.bullet_en = r_bullet_en;
  assign bus.start_dmg = r_start_dmg;
  assign bus.turn_cnt  = r_turn_cnt;
  assign bus.game_over = r_game_over;

endmodule

// File: tb/tb_battle_turn_sequencer.sv
// Scoreboard bench for battle_turn_sequencer: directed game scenarios plus random play,
// checked against a rule-level model of the battle.
module tb_battle_turn_sequencer;

  logic clk;
  logic reset_n;

  battle_turn_sequencer_if bus ();

  battle_turn_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int phase;
    int php;
    int mhp;
    int ben;
    int sdmg;
    int turns;
    int go;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  // Reference model: game rules in plain integer arithmetic.
  int m_ph, m_php, m_mhp, m_turns, m_cnt, m_latch, m_sdmg;

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit tk, input bit kv, input int k,
                            input bit pass, input int dmg, input bit hit, input int hd);
    m_sdmg = 0;
    if (rst) begin
      m_ph = 0; m_php = 100; m_mhp = 100; m_turns = 0; m_cnt = 0; m_latch = 0;
      return;
    end
    case (m_ph)
      0: if (kv) begin m_ph = 1; m_php = 100; m_mhp = 100; m_turns = 0; m_cnt = 0; end
      1: if (kv) begin
           if (k == 'h20) begin m_ph = 2; m_cnt = 0; end
           else if (k == 'h68) begin
             m_php = (m_php + 20 > 100) ? 100 : m_php + 20;
             m_ph = 4; m_cnt = 0;
           end
         end
      2: if (kv && k == 'h20) begin
           m_cnt = 0;
           if (pass) begin m_sdmg = 1; m_latch = dmg; m_ph = 3; end
           else m_ph = 4;
         end else if (tk) begin
           m_cnt++;
           if (m_cnt == 30) begin m_ph = 4; m_cnt = 0; end
         end
      3: begin
           m_mhp = (m_mhp - m_latch < 0) ? 0 : m_mhp - m_latch;
           m_ph = (m_mhp == 0) ? 6 : 4;
         end
      4: begin
           if (hit) m_php = (m_php - hd < 0) ? 0 : m_php - hd;
           if (m_php == 0) begin m_ph = 7; m_cnt = 0; end
           else if (tk) begin
             m_cnt++;
             if (m_cnt == 100) begin m_ph = 5; m_cnt = 0; end
           end
         end
      5: begin m_turns = (m_turns + 1) % 256; m_ph = 1; end
      default: if (kv && k == 'h20) m_ph = 0;
    endcase
  endtask

  // One clock cycle of stimulus; the expected post-edge state is queued for the monitor.
  task automatic cyc(input bit rst, input bit tk, input bit kv, input int k,
                     input bit pass, input int dmg, input bit hit, input int hd);
    exp_t e;
    reset_n        = !rst;
    bus.tick       = tk;
    bus.key_valid  = kv;
    bus.key        = 8'(k);
    bus.atk_pass   = pass;
    bus.dmg_mon    = 8'(dmg);
    bus.player_hit = hit;
    bus.hit_dmg    = 8'(hd);
    model_step(rst, tk, kv, k, pass, dmg, hit, hd);
    e.phase = m_ph;
    e.php   = m_php;
    e.mhp   = m_mhp;
    e.ben   = (m_ph == 4) ? 1 : 0;
    e.sdmg  = m_sdmg;
    e.turns = m_turns;
    e.go    = (m_ph == 6) ? 1 : (m_ph == 7) ? 2 : 0;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic key_in(input int k, input bit pass, input int dmg);
    cyc(0, 0, 1, k, pass, dmg, 0, 0);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("phase",     int'(bus.phase),     e.phase);
      check("player_hp", int'(bus.player_hp), e.php);
      check("mon_hp",    int'(bus.mon_hp),    e.mhp);
      check("bullet_en", int'(bus.bullet_en), e.ben);
      check("start_dmg", int'(bus.start_dmg), e.sdmg);
      check("turn_cnt",  int'(bus.turn_cnt),  e.turns);
      check("game_over", int'(bus.game_over), e.go);
    end
  end

  initial begin
    reset_n = 1'b0;
    bus.tick = 0; bus.key = 0; bus.key_valid = 0; bus.atk_pass = 0;
    bus.dmg_mon = 0; bus.player_hit = 0; bus.hit_dmg = 0;

    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_phase", int'(bus.phase), 0);
    check("rst_hp", int'(bus.player_hp), 100);

    // Start game, strike for 30.
    key_in('h41, 0, 0);
    check("start_phase", int'(bus.phase), 1);
    key_in('h20, 0, 0);
    key_in('h20, 1, 30);
    check("strike_pulse", int'(bus.start_dmg), 1);
    check("apply_phase", int'(bus.phase), 3);
    idle(1);
    check("mon_70", int'(bus.mon_hp), 70);
    check("dodge_phase", int'(bus.phase), 4);
    check("dodge_bullet", int'(bus.bullet_en), 1);

    // Lethal hit on the terminal dodge tick: LOSE wins over CHECK.
    cyc(0, 0, 1, 'h20, 0, 0, 1, 85);
    check("hp_15", int'(bus.player_hp), 15);
    ticks(99);
    cyc(0, 1, 0, 0, 0, 0, 1, 40);
    check("lose_phase", int'(bus.phase), 7);
    check("lose_hp", int'(bus.player_hp), 0);
    check("lose_go", int'(bus.game_over), 2);
    idle(2);
    key_in('h20, 0, 0);
    check("lose_to_idle", int'(bus.phase), 0);

    // Miss, take 5, full dodge, then clamped heal.
    key_in('h41, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 1, 50);
    key_in('h20, 0, 0);
    key_in('h20, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 5);
    check("hp_95", int'(bus.player_hp), 95);
    ticks(100);
    check("check_phase", int'(bus.phase), 5);
    idle(1);
    check("turn_1", int'(bus.turn_cnt), 1);
    check("select_again", int'(bus.phase), 1);
    key_in('h68, 0, 0);
    check("heal_clamp", int'(bus.player_hp), 100);
    check("heal_dodge", int'(bus.phase), 4);

    // Bring the monster to 20, then finish it with 50.
    ticks(100); idle(1);
    key_in('h20, 0, 0); key_in('h20, 1, 80); idle(1);
    check("mon_20", int'(bus.mon_hp), 20);
    ticks(100); idle(1);
    key_in('h20, 0, 0); key_in('h20, 1, 50); idle(1);
    check("win_phase", int'(bus.phase), 6);
    check("win_mon", int'(bus.mon_hp), 0);
    check("win_go", int'(bus.game_over), 1);
    key_in('h41, 0, 0);
    check("win_sticky", int'(bus.phase), 6);
    key_in('h20, 0, 0);
    check("win_idle", int'(bus.phase), 0);
    check("win_clear_go", int'(bus.game_over), 0);

    // Attack timeout, then key colliding with the terminal attack tick.
    key_in('h41, 0, 0); key_in('h41, 0, 0); key_in('h20, 0, 0);
    ticks(29);
    check("atk_wait", int'(bus.phase), 2);
    ticks(1);
    check("atk_timeout", int'(bus.phase), 4);
    ticks(100); idle(1);
    key_in('h20, 0, 0);
    ticks(29);
    cyc(0, 1, 1, 'h20, 1, 10, 0, 0);
    check("key_beats_tick", int'(bus.phase), 3);
    idle(1);
    check("mon_90", int'(bus.mon_hp), 90);

    // Reset mid-dodge.
    ticks(10);
    cyc(0, 0, 0, 0, 0, 0, 1, 7);
    cyc(1, 1, 1, 'h20, 1, 0, 1, 3);
    check("mid_rst_phase", int'(bus.phase), 0);
    check("mid_rst_bullet", int'(bus.bullet_en), 0);
    check("mid_rst_turns", int'(bus.turn_cnt), 0);

    // Random play.
    for (int i = 0; i < 6000; i++) begin
      int r, k;
      bit rst, tk, kv, pass, hit;
      r = int'($urandom_range(0, 3));
      k = (r == 0) ? 'h20 : (r == 1) ? 'h68 : (r == 2) ? 'h41 : int'($urandom_range(0, 255));
      rst  = ($urandom_range(0, 999) == 0);
      tk   = ($urandom_range(0, 1) == 0);
      kv   = ($urandom_range(0, 5) == 0);
      pass = ($urandom_range(0, 1) == 0);
      hit  = ($urandom_range(0, 7) == 0);
      cyc(rst, tk, kv, k, pass, int'($urandom_range(0, 60)), hit, int'($urandom_range(0, 40)));
    end

    idle(1);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
